// File: rtl/riscv_pkg.sv
// Shared definitions for the 32I pipelined core: datapath width, the
// canonical bubble instruction and the fetch beat record passed between
// the fetch unit and the IF/ID stage.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- architecturally a no-op, used as the bubble word.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_beat_t;

  // Sequential successor of a PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur);
    return cur + XLEN'(4);
  endfunction

  // A 32I instruction address must be word aligned.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] cur);
    return |cur[1:0];
  endfunction

endpackage

// File: rtl/if_id_pipe_if.sv
// Fetch-to-IF/ID valid/ready handshake. The fetch unit is the master,
// the IF/ID stage is the slave.
interface if_id_pipe_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     fetch_inst;
  logic            fetch_ready;

  modport master (
    output fetch_valid,
    output fetch_pc,
    output fetch_inst,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_pc,
    input  fetch_inst,
    output fetch_ready
  );

endinterface

// File: rtl/if_id_pipe_skid_buffer.sv
// One-entry capture/replay register. Captures a fetch beat that arrived
// while decode was held, replays it once decode frees up, and is emptied
// by a flush. The stored valid bit doubles as the full flag.
module skid_buffer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        capture,
  input  logic        replay,
  input  fetch_beat_t beat_in,
  output logic        full,
  output fetch_beat_t beat_out
);

  fetch_beat_t store;

  // Priority: reset, then wrong-path clear, then capture, then replay.
  always_ff @(posedge clk) begin
    // NOTE: the data fields are reset too, not just the flag, so the replay
    // path never carries X into decode and the reset image is fully defined.
    if (reset) begin
      store.valid <= 1'b0;
      store.pc    <= '0;
      store.inst  <= NOP_INST;
    end else if (clear) begin
      store.valid <= 1'b0;
    end else if (capture) begin
      store.valid <= 1'b1;
      store.pc    <= beat_in.pc;
      store.inst  <= beat_in.inst;
    end else if (replay) begin
      store.valid <= 1'b0;
    end
  end

  assign full     = store.valid;
  assign beat_out = store;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register. Presents one registered instruction to decode,
// holds it across hazard stalls, turns it into a bubble on flush, and uses
// a one-entry skid buffer so the beat arriving with a stall is not lost.
module if_id_pipe
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  if_id_pipe_if.slave     fetch,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [31:0]     inst,
  output logic            misaligned
);

  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;

  logic            skid_full;
  fetch_beat_t     skid_beat;
  fetch_beat_t     in_beat;

  logic            xfer;
  logic            capture;
  logic            replay;

  // The stage only refuses beats while the skid slot is occupied (or in
  // reset), so a beat offered in a stall's first cycle always has a home.
  assign fetch.fetch_ready = !reset && !skid_full;
  assign xfer              = fetch.fetch_valid && fetch.fetch_ready;

  // A beat taken while decode holds goes into the skid; a flush in the
  // same cycle marks it wrong-path so it is not captured.
  assign capture = xfer && stall && !flush;
  assign replay  = skid_full && !stall && !flush;

  assign in_beat = '{valid: 1'b1, pc: fetch.fetch_pc, inst: fetch.fetch_inst};

  skid_buffer u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .capture  (capture),
    .replay   (replay),
    .beat_in  (in_beat),
    .full     (skid_full),
    .beat_out (skid_beat)
  );

  // Output register: reset > flush > stall (hold) > advance. On advance the
  // skid drains first so program order is kept.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order across blocks.
    if (reset) begin
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
      out_inst  <= NOP_INST;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_inst  <= NOP_INST;
    end else if (!stall) begin
      if (skid_full) begin
        out_valid <= skid_beat.valid;
        out_pc    <= skid_beat.pc;
        out_inst  <= skid_beat.inst;
      end else if (xfer) begin
        out_valid <= 1'b1;
        out_pc    <= fetch.fetch_pc;
        out_inst  <= fetch.fetch_inst;
      end else begin
        out_valid <= 1'b0;
        out_inst  <= NOP_INST;
      end
    end
  end

  assign valid      = out_valid;
  assign pc         = out_pc;
  assign inst       = out_inst;
  assign pc4        = next_pc(out_pc);
  assign misaligned = out_valid && pc_misaligned(out_pc);

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_if_id_pipe;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        misaligned;

  int n_vec = 0;
  int n_err = 0;

  if_id_pipe_if fif ();

  if_id_pipe #(
    .XLEN     (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .fetch      (fif.slave),
    .valid      (valid),
    .pc         (pc),
    .pc4        (pc4),
    .inst       (inst),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  // Reference model: the presented instruction plus a FIFO of instructions
  // accepted but not yet presented.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  fetch_beat_t m_wait[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic r);
    return !r && (m_wait.size() == 0);
  endfunction

  task automatic model_edge(input logic r, input logic st, input logic fl,
                            input logic fv, input logic [31:0] fpc,
                            input logic [31:0] finst);
    logic        acc;
    fetch_beat_t b;
    acc = fv && model_ready(r);
    if (r) begin
      m_valid = 1'b0;
      m_pc    = RESET_PC;
      m_inst  = NOP_INST;
      m_wait.delete();
    end else if (fl) begin
      m_valid = 1'b0;
      m_inst  = NOP_INST;
      m_wait.delete();
    end else if (st) begin
      if (acc) m_wait.push_back('{valid: 1'b1, pc: fpc, inst: finst});
    end else if (m_wait.size() != 0) begin
      b       = m_wait.pop_front();
      m_valid = 1'b1;
      m_pc    = b.pc;
      m_inst  = b.inst;
    end else if (acc) begin
      m_valid = 1'b1;
      m_pc    = fpc;
      m_inst  = finst;
    end else begin
      m_valid = 1'b0;
      m_inst  = NOP_INST;
    end
  endtask

  // One clock: drive inputs, check fetch_ready, clock, check the outputs.
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic fv, input logic [31:0] fpc,
                      input logic [31:0] finst);
    reset           = r;
    stall           = st;
    flush           = fl;
    fif.fetch_valid = fv;
    fif.fetch_pc    = fpc;
    fif.fetch_inst  = finst;
    #1;
    check("fetch_ready", {31'b0, fif.fetch_ready}, {31'b0, model_ready(r)});
    @(posedge clk);
    model_edge(r, st, fl, fv, fpc, finst);
    @(negedge clk);
    check("valid", {31'b0, valid}, {31'b0, m_valid});
    check("pc", pc, m_pc);
    check("inst", inst, m_inst);
    check("pc4", pc4, m_pc + 32'd4);
    check("misaligned", {31'b0, misaligned}, {31'b0, m_valid && (m_pc[1:0] != 2'b00)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        r, st, fl, fv;
    logic [31:0] fpc, finst;
    int          sel;

    m_valid = 1'b0;
    m_pc    = RESET_PC;
    m_inst  = NOP_INST;

    // Reset then a straight stream.
    step(1, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0000_0000, 32'h0050_0093);
    step(0, 0, 0, 1, 32'h0000_0004, 32'h00A0_0113);
    step(0, 0, 0, 1, 32'h0000_0008, 32'h0020_81B3);

    // Stall with a skidded beat.
    step(0, 0, 0, 1, 32'h0000_0010, 32'h1111_0013);
    step(0, 1, 0, 1, 32'h0000_0014, 32'h2222_0013);
    step(0, 1, 0, 1, 32'h0000_0018, 32'h3333_0013);
    step(0, 1, 0, 1, 32'h0000_0018, 32'h3333_0013);
    step(0, 0, 0, 1, 32'h0000_0018, 32'h3333_0013);
    step(0, 0, 0, 1, 32'h0000_0018, 32'h3333_0013);

    // Flush with output and skid both occupied.
    step(0, 0, 0, 1, 32'h0000_0020, 32'h4444_0013);
    step(0, 1, 0, 1, 32'h0000_0024, 32'h5555_0013);
    step(0, 0, 1, 1, 32'h0000_0028, 32'h6666_0013);
    step(0, 0, 0, 1, 32'h0000_0040, 32'h7777_0013);

    // Flush and stall together.
    step(0, 0, 0, 1, 32'h0000_0044, 32'h8888_0013);
    step(0, 1, 1, 1, 32'h0000_0048, 32'h9999_0013);
    step(0, 0, 0, 0, 32'h0000_004C, 32'hAAAA_0013);

    // Reset while stalled with a full skid.
    step(0, 0, 0, 1, 32'h0000_0050, 32'hBBBB_0013);
    step(0, 1, 0, 1, 32'h0000_0054, 32'hCCCC_0013);
    step(1, 1, 0, 1, 32'h0000_0058, 32'hDDDD_0013);
    step(0, 0, 0, 1, 32'h0000_005C, 32'hEEEE_0013);

    // Boundaries: PC wrap and misalignment, cleared by a flush.
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0093);
    step(0, 0, 0, 1, 32'h0000_0102, 32'h0000_0113);
    step(0, 0, 1, 0, 32'h0000_0000, 32'h0000_0000);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      fv  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 7);
      if (sel == 0)      fpc = 32'hFFFF_FFFC;
      else if (sel == 1) fpc = $urandom;
      else               fpc = $urandom & 32'hFFFF_FFFC;
      finst = $urandom;
      step(r, st, fl, fv, fpc, finst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
